// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register with valid/ready handshake, flush and optional skid entry
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int MEM_W  = 2,
  parameter int WB_W   = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_E,
  output logic              ready_E,
  input  logic [MEM_W-1:0]  MEM_E,
  input  logic [WB_W-1:0]   WB_E,
  input  logic [DATA_W-1:0] ALUOut_E,
  input  logic [DATA_W-1:0] WriteData_E,
  input  logic [REG_W-1:0]  WriteReg_E,
  output logic              valid_M,
  input  logic              ready_M,
  output logic [MEM_W-1:0]  MEM_M,
  output logic [WB_W-1:0]   WB_M,
  output logic [DATA_W-1:0] ALUOut_M,
  output logic [DATA_W-1:0] WriteData_M,
  output logic [REG_W-1:0]  WriteReg_M
);
  localparam int PW = MEM_W + WB_W + 2 * DATA_W + REG_W;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
  state_t state, state_n;
  logic [PW-1:0] main_q, skid_q, in_p;
  logic [MEM_W-1:0] mem_q;
  logic [WB_W-1:0] wb_q;
  logic rdy_en, acc, drn, load_main, load_skid, from_skid;
  assign in_p = {MEM_E, WB_E, ALUOut_E, WriteData_E, WriteReg_E};
  assign {mem_q, wb_q, ALUOut_M, WriteData_M, WriteReg_M} = main_q;
  assign valid_M = state != ST_EMPTY;
  assign MEM_M = valid_M ? mem_q : '0;
  assign WB_M = valid_M ? wb_q : '0;
  // rdy_en keeps ready_E low until the first edge after reset
  assign ready_E = rdy_en & ((SKID != 0) ? (state != ST_SKID) : (~valid_M | ready_M));
  assign acc = valid_E & ready_E;
  assign drn = valid_M & ready_M;
  always_comb begin
    state_n = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      ST_EMPTY: if (acc) begin
        state_n = ST_FULL;
        load_main = 1'b1;
      end
      ST_FULL: if (acc && drn) load_main = 1'b1;
      else if (drn) state_n = ST_EMPTY;
      else if (acc && SKID != 0) begin
        state_n = ST_SKID;
        load_skid = 1'b1;
      end
      ST_SKID: if (drn) begin
        state_n = ST_FULL;
        load_main = 1'b1;
        from_skid = 1'b1;
      end
      default: state_n = ST_EMPTY;
    endcase
    if (flush) begin
      state_n = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      rdy_en <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      rdy_en <= 1'b1;
      if (load_main) main_q <= from_skid ? skid_q : in_p;
      if (load_skid) skid_q <= in_p;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: scoreboard bench driving a SKID=0 (index 0) and a SKID=1 (index 1) instance in parallel
module tb_ex_mem_stage_reg;
  localparam int DATA_W = 32, REG_W = 5, MEM_W = 2, WB_W = 2;
  localparam int PW = MEM_W + WB_W + 2 * DATA_W + REG_W;
  typedef logic [PW-1:0] pl_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, valid_E = 1'b0, ready_M = 1'b0;
  logic [MEM_W-1:0] MEM_E = '0;
  logic [WB_W-1:0] WB_E = '0;
  logic [DATA_W-1:0] ALUOut_E = '0, WriteData_E = '0;
  logic [REG_W-1:0] WriteReg_E = '0;
  logic r_e [2];
  logic v_m [2];
  logic [MEM_W-1:0] mem_m [2];
  logic [WB_W-1:0] wb_m [2];
  logic [DATA_W-1:0] alu_m [2], wd_m [2];
  logic [REG_W-1:0] wr_m [2];
  pl_t p_m [2];
  pl_t in_p;
  pl_t q [2][$];
  logic rdy_ok, exp_r, a, d;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign in_p = {MEM_E, WB_E, ALUOut_E, WriteData_E, WriteReg_E};
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .MEM_W(MEM_W), .WB_W(WB_W), .SKID(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .valid_E(valid_E), .ready_E(r_e[g]),
      .MEM_E(MEM_E), .WB_E(WB_E), .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E), .WriteReg_E(WriteReg_E),
      .valid_M(v_m[g]), .ready_M(ready_M), .MEM_M(mem_m[g]), .WB_M(wb_m[g]),
      .ALUOut_M(alu_m[g]), .WriteData_M(wd_m[g]), .WriteReg_M(wr_m[g])
    );
    assign p_m[g] = {mem_m[g], wb_m[g], alu_m[g], wd_m[g], wr_m[g]};
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                       input logic [REG_W-1:0] wr, input logic [MEM_W-1:0] mem, input logic [WB_W-1:0] wb);
    valid_E = v;
    ALUOut_E = alu;
    WriteData_E = wd;
    WriteReg_E = wr;
    MEM_E = mem;
    WB_E = wb;
  endtask
  always @(posedge clk or negedge rst_n) rdy_ok <= rst_n;
  // reference model: one in-order queue of held entries per instance, updated for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
    end else for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid_M[%0d]", k), v_m[k], q[k].size() != 0);
      if (q[k].size() != 0) chk($sformatf("payload[%0d]", k), p_m[k], q[k][0]);
      else chk($sformatf("bubble_ctl[%0d]", k), {mem_m[k], wb_m[k]}, 0);
      exp_r = rdy_ok && ((k == 1) ? q[k].size() < 2 : (q[k].size() == 0 || ready_M));
      chk($sformatf("ready_E[%0d]", k), r_e[k], exp_r);
      a = valid_E & r_e[k];
      d = v_m[k] & ready_M;
      if (flush) q[k].delete();
      else begin
        if (d && q[k].size() != 0) void'(q[k].pop_front());
        if (a) q[k].push_back(in_p);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", v_m[k], 0);
      chk("rst_ready", r_e[k], 0);
      chk("rst_data", p_m[k], 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("post_rst_ready", r_e[k], 1);
    // streaming with MEM always ready: one-cycle latency, fields not crossed
    ready_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 32'hA0 + i, 5'(3 + i), 2'(i + 1), 2'(3 - i));
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("stream_alu", alu_m[k], 32'h11 * (i + 1));
        chk("stream_wd", wd_m[k], 32'hA0 + i);
        chk("stream_wr", wr_m[k], 3 + i);
      end
    end
    valid_E = 1'b0;
    tick();
    // skid backpressure and in-order drain
    drive(1'b1, 32'h11, 32'hB1, 5'd7, 2'd1, 2'd1);
    tick();
    ready_M = 1'b0;
    drive(1'b1, 32'h22, 32'hB2, 5'd8, 2'd2, 2'd2);
    tick();
    chk("skid_ready", r_e[1], 0);
    chk("skid_head", alu_m[1], 32'h11);
    chk("s0_hold", alu_m[0], 32'h11);
    chk("s0_ready_low", r_e[0], 0);
    valid_E = 1'b0;
    tick();
    chk("skid_hold", alu_m[1], 32'h11);
    ready_M = 1'b1;
    #1;
    chk("s0_ready_comb", r_e[0], 1);
    chk("skid_ready_reg", r_e[1], 0);
    tick();
    chk("skid_second", alu_m[1], 32'h22);
    chk("skid_ready_back", r_e[1], 1);
    tick();
    chk("skid_drained", v_m[1], 0);
    // flush while holding a skid entry, with a same-cycle input
    drive(1'b1, 32'h55, 32'hC5, 5'd9, 2'd3, 2'd3);
    tick();
    ready_M = 1'b0;
    drive(1'b1, 32'h66, 32'hC6, 5'd10, 2'd3, 2'd3);
    tick();
    chk("pre_flush_skid", r_e[1], 0);
    flush = 1'b1;
    drive(1'b1, 32'h44, 32'hC4, 5'd11, 2'd3, 2'd3);
    tick();
    flush = 1'b0;
    valid_E = 1'b0;
    chk("flush_valid", v_m[1], 0);
    chk("flush_ctl", {mem_m[1], wb_m[1]}, 0);
    chk("flush_ready", r_e[1], 1);
    ready_M = 1'b1;
    repeat (3) begin
      tick();
      for (int k = 0; k < 2; k++) chk("flush_quiet", v_m[k], 0);
    end
    // single-entry mode: simultaneous accept and drain
    drive(1'b1, 32'h77, 32'hD7, 5'd12, 2'd1, 2'd2);
    tick();
    ready_M = 1'b0;
    drive(1'b1, 32'h88, 32'hD8, 5'd13, 2'd2, 2'd1);
    #1;
    chk("s0_ready_bp", r_e[0], 0);
    ready_M = 1'b1;
    #1;
    chk("s0_ready_rise", r_e[0], 1);
    tick();
    chk("s0_pass", alu_m[0], 32'h88);
    chk("s0_pass_valid", v_m[0], 1);
    valid_E = 1'b0;
    repeat (2) tick();
    // asynchronous reset mid-operation
    ready_M = 1'b0;
    drive(1'b1, 32'h99, 32'hE9, 5'd14, 2'd3, 2'd1);
    tick();
    valid_E = 1'b0;
    for (int k = 0; k < 2; k++) chk("pre_rst_full", v_m[k], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_valid", v_m[k], 0);
      chk("async_data", p_m[k], 0);
      chk("async_ready", r_e[k], 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("rerst_ready", r_e[k], 1);
    // random traffic against the scoreboard
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
      ready_M = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      tick();
    end
    flush = 1'b0;
    valid_E = 1'b0;
    ready_M = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      chk("final_empty", q[k].size(), 0);
      chk("final_valid", v_m[k], 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX→MEM pipeline boundary register with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer.
- Carries the MEM control field, WB control field, ALU result, store data and destination register index from EX to MEM.
- Replaces fixed-width, always-advancing stage registers, so hazard logic can stall and squash the stage without corrupting in-flight data.

Parameters:
DATA_W  32  width of ALUOut and WriteData fields
REG_W   5  width of destination register index
MEM_W   2  width of MEM-stage control field
WB_W    2  width of WB-stage control field
SKID    1  1 = 2-entry skid buffer with registered ready_E; 0 = single entry with combinational ready_E

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries and of same-cycle input
valid_E  in  1  EX presents a valid instruction
ready_E  out  1  stage can accept an instruction this cycle
MEM_E  in  MEM_W  MEM control from EX
WB_E  in  WB_W  WB control from EX
ALUOut_E  in  DATA_W  ALU result
WriteData_E  in  DATA_W  store data
WriteReg_E  in  REG_W  destination register
valid_M  out  1  MEM-side entry valid
ready_M  in  1  MEM stage accepts the entry this cycle
MEM_M  out  MEM_W  MEM control (zero whenever valid_M=0)
WB_M  out  WB_W  WB control (zero whenever valid_M=0)
ALUOut_M  out  DATA_W  ALU result
WriteData_M  out  DATA_W  store data
WriteReg_M  out  REG_W  destination register

Behaviour:
- Reset (rst_n low, async): all outputs 0, skid entry invalid, ready_E=0. First cycle after release: ready_E=1.
- Accept = valid_E & ready_E. Drain = valid_M & ready_M. Both are sampled at the posedge.
- Field mapping is strict and one-to-one: each *_E field is captured into its own *_M field. In particular, WriteData_M ← WriteData_E and WriteReg_M ← WriteReg_E.
- MEM_M and WB_M are forced to 0 when valid_M=0, which produces a bubble with no side effects. Data fields hold their last value when invalid.
- Latency: 1 cycle from accept to appearing on the *_M outputs when the stage was empty or draining.
- SKID=1 state machine (EMPTY, FULL, SKID):
  - EMPTY: accept → FULL (main loaded).
  - FULL, accept & drain: main reloaded; stays FULL.
  - FULL, drain only: → EMPTY.
  - FULL, accept only: incoming entry goes to the skid register; → SKID.
  - FULL, neither: hold.
  - SKID: ready_E=0; drain → FULL with main ← skid; otherwise hold.
  - ready_E = (state != SKID), registered. It has no combinational path from ready_M.
- SKID=0: a single entry with ready_E = ~valid_M | ready_M (combinational).
  - Accept loads main.
  - Drain without accept clears valid.
- Ordering: entries leave in arrival order; the skid entry never overtakes main.
- Flush (highest priority over accept and drain):
  - Next state is EMPTY; valid_M=0; skid invalidated.
  - An instruction accepted in the same cycle is discarded.
  - ready_E is 1 the following cycle.
- valid_E dropping while ready_E=0 is legal: nothing is captured.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
1. Reset then stream with ready_M=1, valid_E=1: inputs ALUOut=0x11,0x22,0x33, WriteData=0xA0,.., WriteReg=3,4,5. Required: each appears on *_M exactly 1 cycle later; WriteData_M=0xA0 while WriteReg_M=3 (fields not crossed).
2. SKID=1 backpressure: with FULL holding 0x11, drop ready_M and accept 0x22. Required: the next cycle is state SKID and ready_E=0, with 0x11 still on ALUOut_M. When ready_M rises, 0x11 then 0x22 drain in order, and ready_E returns to 1.
3. Flush while in SKID with valid_E=1 carrying 0x44. Required: next cycle valid_M=0, MEM_M=WB_M=0, ready_E=1. Neither 0x44 nor the skid entry ever appears with valid_M=1.
4. SKID=0 with ready_M=0 and valid_M=1. Required: ready_E=0 combinationally. Raising ready_M in the same cycle makes ready_E=1, giving simultaneous accept and drain.
5. Assert rst_n low between clock edges while FULL. Required: valid_M, all data fields and ready_E go to 0 immediately. After release, ready_E=1 on the first post-reset edge.
